// File: rtl/fp_normalize_seq.sv
// Normalizer for the 12-bit two's-complement to 8-bit float (1/3/4) converter.
// Ports: clk, rst_n, in_valid/in_ready/d_in, out_valid/out_ready, s/e/sig/fb_out.
module fp_normalize_seq (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [11:0] d_in,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        s_out,
   output logic [2:0]  e_out,
   output logic [3:0]  sig_out,
   output logic        fb_out
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      NORM = 2'd1,
      OUT  = 2'd2
   } state_t;

   state_t      state;
   state_t      state_nx;
   logic        sgn;
   logic [11:0] mag;
   logic [2:0]  exp;
   logic        sat;
   logic [11:0] abs_in;
   logic        done;

   // -2048 wraps back to 12'h800; sat catches it
   assign abs_in = d_in[11] ? (~d_in + 12'd1) : d_in;

   // stop on leading one at bit 10 or once exponent has bottomed out
   assign done = mag[10] | (exp == 3'd0);

   // in_ready forced low while reset is asserted
   assign in_ready  = rst_n & (state == IDLE);
   assign out_valid = (state == OUT);

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE: if (in_valid) state_nx = NORM;
         NORM: if (sat | done) state_nx = OUT;
         OUT:  if (out_ready) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         sgn     <= 1'b0;
         mag     <= '0;
         exp     <= '0;
         sat     <= 1'b0;
         s_out   <= 1'b0;
         e_out   <= '0;
         sig_out <= '0;
         fb_out  <= 1'b0;
      end else begin
         state <= state_nx;
         unique case (state)
            IDLE: begin
               if (in_valid) begin
                  sgn <= d_in[11];
                  mag <= abs_in;
                  exp <= 3'd7;
                  sat <= (d_in == 12'h800);
               end
            end
            NORM: begin
               if (sat) begin
                  s_out   <= sgn;
                  e_out   <= 3'd7;
                  sig_out <= 4'b1111;
                  fb_out  <= 1'b0;
               end else if (done) begin
                  s_out   <= sgn;
                  e_out   <= exp;
                  sig_out <= mag[10:7];
                  fb_out  <= mag[6];
               end else begin
                  mag <= {mag[10:0], 1'b0};
                  exp <= exp - 3'd1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
